// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider.
// One quotient bit per clock, start/busy/done handshake.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] prem_q;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] dvsr_q;

  logic             accept;
  logic             zero_div;
  logic             last;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] prem_nx;
  logic [WIDTH-1:0] sreg_nx;

  // a new request is taken from IDLE or DONE, never while RUN
  assign accept   = start & (state_q != RUN);
  assign zero_div = (divisor == '0);
  assign last     = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    shifted = {prem_q, sreg_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr_q};
    sreg_nx = {sreg_q[WIDTH-2:0], ~trial[WIDTH]};
    prem_nx = shifted[WIDTH-1:0];
    if (!trial[WIDTH]) begin
      prem_nx = trial[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = zero_div ? DONE : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (last) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      prem_q      <= '0;
      sreg_q      <= '0;
      dvsr_q      <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt_q       <= '0;
      prem_q      <= '0;
      sreg_q      <= dividend;
      dvsr_q      <= divisor;
      quotient    <= zero_div ? '1 : '0;
      remainder   <= zero_div ? dividend : '0;
      div_by_zero <= zero_div;
    end else if (state_q == RUN) begin
      cnt_q  <= cnt_q + 1'b1;
      prem_q <= prem_nx;
      sreg_q <= sreg_nx;
      if (last) begin
        quotient  <= sreg_nx;
        remainder <= prem_nx;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table-driven and scoreboard bench
// for the sequential restoring divider.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[13];
  int   pass = 0;
  int   total = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
      e.z = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.z = 1'b0;
    end
    return e;
  endfunction

  // scoreboard: every done pulse pops one expected result
  always @(negedge clk) begin
    if (rst_n && done) begin
      chk("excl_busy", busy, 0);
      if (sb.size() == 0) begin
        total++;
        $display("FAIL sb_empty: got done want none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_q", quotient, e.q);
        chk("sb_r", remainder, e.r);
        chk("sb_z", div_by_zero, e.z);
      end
    end
  end

  task automatic issue(input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input exp_t e,
                       input bit now);
    if (!now) @(negedge clk);
    start = 1'b1;
    dividend = a;
    divisor = b;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = W'($urandom);
    divisor = W'($urandom);
    chk("acc_busy", busy, (b != 0));
    chk("acc_q", quotient, (b == 0) ? 32'hFF : 32'h0);
    chk("acc_r", remainder, (b == 0) ? 32'(a) : 32'h0);
    chk("acc_z", div_by_zero, (b == 0));
  endtask

  task automatic wait_done(input exp_t e,
                           input int exp_lat,
                           input bit hold_chk,
                           input int inj);
    int n = 0;
    int nb = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) nb++;
      if (inj > 0 && n == inj) begin
        start = 1'b1;
        dividend = 8'd50;
        divisor = 8'd5;
      end else if (inj > 0 && n == inj + 1) begin
        start = 1'b0;
      end
    end while (!done && n < 40);
    chk("latency", n, exp_lat);
    chk("busy_cycles", nb, exp_lat - 1);
    if (hold_chk) begin
      @(negedge clk);
      chk("hold_done", done, 0);
      chk("hold_q", quotient, e.q);
      chk("hold_r", remainder, e.r);
      chk("hold_z", div_by_zero, e.z);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    exp_t e2;
    int   bad;

    tbl[0]  = '{8'd11,  8'd4,   8'd2,   8'd3,   1'b0};
    tbl[1]  = '{8'd240, 8'd2,   8'd120, 8'd0,   1'b0};
    tbl[2]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
    tbl[3]  = '{8'd3,   8'd200, 8'd0,   8'd3,   1'b0};
    tbl[4]  = '{8'd7,   8'd0,   8'hFF,  8'd7,   1'b1};
    tbl[5]  = '{8'd9,   8'd3,   8'd3,   8'd0,   1'b0};
    tbl[6]  = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
    tbl[7]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
    tbl[8]  = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0};
    tbl[9]  = '{8'd1,   8'd0,   8'hFF,  8'd1,   1'b1};
    tbl[10] = '{8'd128, 8'd128, 8'd1,   8'd0,   1'b0};
    tbl[11] = '{8'd200, 8'd9,   8'd22,  8'd2,   1'b0};
    tbl[12] = '{8'd127, 8'd16,  8'd7,   8'd15,  1'b0};

    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_z", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      e.q = tbl[i].q;
      e.r = tbl[i].r;
      e.z = tbl[i].z;
      issue(tbl[i].a, tbl[i].b, e, 1'b0);
      wait_done(e, (tbl[i].b == 0) ? 1 : 9, 1'b1, 0);
    end

    // start during RUN is ignored and not queued
    e = model(8'd100, 8'd7);
    issue(8'd100, 8'd7, e, 1'b0);
    wait_done(e, 9, 1'b1, 4);
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy || done) bad++;
    end
    chk("no_queue", bad, 0);

    // back-to-back from DONE, including through divide by zero
    e = model(8'd255, 8'd1);
    issue(8'd255, 8'd1, e, 1'b0);
    wait_done(e, 9, 1'b0, 0);
    e2 = model(8'd200, 8'd9);
    issue(8'd200, 8'd9, e2, 1'b1);
    wait_done(e2, 9, 1'b0, 0);
    e = model(8'd5, 8'd0);
    issue(8'd5, 8'd0, e, 1'b1);
    wait_done(e, 1, 1'b0, 0);
    e2 = model(8'd6, 8'd2);
    issue(8'd6, 8'd2, e2, 1'b1);
    wait_done(e2, 9, 1'b1, 0);

    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom);
      b = W'($urandom_range(0, 255));
      if (i == 7) b = '0;
      e = model(a, b);
      issue(a, b, e, 1'b0);
      wait_done(e, (b == 0) ? 1 : 9, 1'b1, 0);
    end

    // asynchronous reset mid-RUN
    e = model(8'd200, 8'd3);
    issue(8'd200, 8'd3, e, 1'b0);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_q", quotient, 0);
    chk("arst_r", remainder, 0);
    chk("arst_z", div_by_zero, 0);
    sb.delete();
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy || done) bad++;
    end
    chk("rst_hold", bad, 0);
    rst_n = 1'b1;
    issue(8'd200, 8'd3, e, 1'b0);
    wait_done(e, 9, 1'b1, 0);

    repeat (2) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
